// File: rtl/mul_sequencer_pkg.sv
// Shared constants for the multi-cycle multiplier sequencer: word width and FSM encodings.
package mul_sequencer_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mul_sequencer_shift_add_unit.sv
// Shift-add datapath: accumulator plus shifting multiplicand/multiplier registers.
// MUL_EARLY_TERM_EN adds a flag indicating the multiplier is exhausted after this step.
module shift_add_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplr_in,
`ifdef MUL_EARLY_TERM_EN
  output logic             rem_zero_c,
`endif
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;

  // One multiplier bit consumed per step; overflow past WIDTH bits is discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= mcand_in;
      mplr  <= mplr_in;
    end else if (step) begin
      if (mplr[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
    end
  end

`ifdef MUL_EARLY_TERM_EN
  assign rem_zero_c = ((mplr >> 1) == '0);
`endif

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL sequencer: stalls the pipeline while shift_add_unit iterates, then
// presents product and flags for one DONE cycle. MUL_EARLY_TERM_EN enables early completion.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             S_in,
  input  logic [3:0]       Status_Register_in,
  input  logic [WIDTH-1:0] Val_Rn,
  input  logic [WIDTH-1:0] Val_Rm,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] MUL_Res,
  output logic [3:0]       Status_Register_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e         state;
  state_e         state_nx;
  logic [CW-1:0]  cnt;
  logic           s_q;
  logic [3:0]     sr_q;
  logic           load;
  logic           step;
  logic           last_c;

`ifdef MUL_EARLY_TERM_EN
  logic rem_zero_c;
  assign last_c = (cnt == CW'(WIDTH - 1)) || rem_zero_c;
`else
  assign last_c = (cnt == CW'(WIDTH - 1));
`endif

  shift_add_unit #(.WIDTH(WIDTH)) u_shift_add (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .mcand_in   (Val_Rn),
    .mplr_in    (Val_Rm),
`ifdef MUL_EARLY_TERM_EN
    .rem_zero_c (rem_zero_c),
`endif
    .acc        (MUL_Res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and control; flush overrides everything, including the BUSY->DONE exit
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx = BUSY;
        load     = 1'b1;
        stall    = 1'b1;
      end
      BUSY: begin
        step  = 1'b1;
        stall = 1'b1;
        if (last_c) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      load     = 1'b0;
      step     = 1'b0;
      stall    = 1'b0;
      done     = 1'b0;
    end
  end

  // Iteration counter and flag-update context captured with the command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      s_q  <= 1'b0;
      sr_q <= '0;
    end else if (load) begin
      cnt  <= '0;
      s_q  <= S_in;
      sr_q <= Status_Register_in;
    end else if (step) begin
      cnt  <= cnt + CW'(1);
    end
  end

  // MUL only defines N and Z; C and V pass through from the captured flags
  assign Status_Register_out = s_q ? {MUL_Res[WIDTH-1], (MUL_Res == '0), sr_q[1], sr_q[0]}
                                   : sr_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: vector table, random ops vs. arithmetic model,
// and hand-written flush / reset / busy-restart sequences.
module tb_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic        S_in;
  logic [3:0]  Status_Register_in;
  logic [31:0] Val_Rn;
  logic [31:0] Val_Rm;
  logic        stall;
  logic        done;
  logic [31:0] MUL_Res;
  logic [3:0]  Status_Register_out;

  int n_pass  = 0;
  int n_total = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .flush               (flush),
    .S_in                (S_in),
    .Status_Register_in  (Status_Register_in),
    .Val_Rn              (Val_Rn),
    .Val_Rm              (Val_Rm),
    .stall               (stall),
    .done                (done),
    .MUL_Res             (MUL_Res),
    .Status_Register_out (Status_Register_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  sr;
    logic [31:0] exp_res;
    logic [3:0]  exp_sr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Cycles from the start cycle to the done cycle
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return h + 2;
`else
    return 33;
`endif
  endfunction

  function automatic logic [3:0] model_sr(input logic [31:0] res, input logic s, input logic [3:0] sr);
    return s ? {res[31], (res == 32'd0), sr[1], sr[0]} : sr;
  endfunction

  // Issue one MUL starting at a negedge; returns at a negedge with the sequencer back in IDLE
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [3:0] sr, output logic [31:0] res, output logic [3:0] sro,
                        output int lat, output int stall_bad);
    stall_bad = 0;
    lat = 0;
    res = 'x;
    sro = 'x;
    start = 1'b1; Val_Rn = a; Val_Rm = b; S_in = s; Status_Register_in = sr;
    #1;
    if (stall !== 1'b1) stall_bad++;
    @(negedge clk);
    start = 1'b0; Val_Rn = $urandom; Val_Rm = $urandom; S_in = 1'b0; Status_Register_in = 4'h0;
    #1;
    for (int c = 1; c <= 100; c++) begin
      if (done === 1'b1) begin
        lat = c;
        res = MUL_Res;
        sro = Status_Register_out;
        if (stall !== 1'b0) stall_bad++;
        break;
      end
      if (stall !== 1'b1) stall_bad++;
      @(negedge clk);
    end
    @(negedge clk);
    if (done !== 1'b0 || stall !== 1'b0) stall_bad++;
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [3:0] sr,
                          input logic [31:0] exp_res, input logic [3:0] exp_sr);
    logic [31:0] res;
    logic [3:0]  sro;
    int lat, sb;
    run_op(a, b, s, sr, res, sro, lat, sb);
    chk({tag, " res"}, 64'(res), 64'(exp_res));
    chk({tag, " sr"}, 64'(sro), 64'(exp_sr));
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(b)));
    chk({tag, " stall/done shape"}, 64'(sb), 64'd0);
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] a, b, ex;
    logic        s;
    logic [3:0]  sr;
    int          ndone;
    logic [31:0] got;

    vecs[0] = '{32'd7,        32'd6,        1'b0, 4'b1010, 32'd42,         4'b1010};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'b0011, 32'd1,          4'b0011};
    vecs[2] = '{32'd5,        32'd0,        1'b1, 4'b0000, 32'd0,          4'b0100};
    vecs[3] = '{32'h80000000, 32'd2,        1'b1, 4'b0000, 32'd0,          4'b0100};
    vecs[4] = '{32'h00010000, 32'h00008000, 1'b1, 4'b0000, 32'h80000000,   4'b1000};
    vecs[5] = '{32'd3,        32'hFFFFFFFF, 1'b1, 4'b0110, 32'hFFFFFFFD,   4'b1010};
    vecs[6] = '{32'd12345,    32'd1,        1'b0, 4'b1111, 32'd12345,      4'b1111};

    rst = 1'b1; start = 1'b0; flush = 1'b0; S_in = 1'b0;
    Status_Register_in = 4'h0; Val_Rn = 32'h0; Val_Rm = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset MUL_Res", 64'(MUL_Res), 64'd0);
    chk("reset SR_out", 64'(Status_Register_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].sr,
               vecs[i].exp_res, vecs[i].exp_sr);

    for (int i = 0; i < 20; i++) begin
      logic [63:0] prod;
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      s  = 1'($urandom_range(0, 1));
      sr = 4'($urandom_range(0, 15));
      prod = 64'(a) * 64'(b);
      check_op($sformatf("rand%0d", i), a, b, s, sr, prod[31:0], model_sr(prod[31:0], s, sr));
    end

    // Flush at BUSY cycle 10: abort, no done, then a fresh op completes
    start = 1'b1; Val_Rn = 32'd100; Val_Rm = 32'h80000003; S_in = 1'b1; Status_Register_in = 4'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush stall same cycle", 64'(stall), 64'd0);
    chk("flush done same cycle", 64'(done), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush idle stall", 64'(stall), 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("flush no done", 64'(ndone), 64'd0);
    check_op("after flush", 32'd1234, 32'd5678, 1'b1, 4'b0001, 32'd7006652, 4'b0001);

    // Reset pulse at BUSY cycle 5: outputs clear immediately, then normal operation resumes
    start = 1'b1; Val_Rn = 32'hDEADBEEF; Val_Rm = 32'hFFFF0000; S_in = 1'b1; Status_Register_in = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst mid stall", 64'(stall), 64'd0);
    chk("rst mid done", 64'(done), 64'd0);
    chk("rst mid MUL_Res", 64'(MUL_Res), 64'd0);
    chk("rst mid SR_out", 64'(Status_Register_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check_op("after rst", 32'd7, 32'd6, 1'b1, 4'b0000, 32'd42, 4'b0000);

    // Start pulses while BUSY must be ignored: exactly one done with the first product
    start = 1'b1; Val_Rn = 32'd9; Val_Rm = 32'h00000F0B; S_in = 1'b0; Status_Register_in = 4'h5;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    got = 32'h0;
    ex = 32'd9 * 32'h00000F0B;
    for (int c = 1; c < 80; c++) begin
      start = (c >= 1 && c <= 3);
      Val_Rn = 32'd2; Val_Rm = 32'd3;
      #1;
      if (done === 1'b1) begin
        ndone++;
        got = MUL_Res;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy restart done count", 64'(ndone), 64'd1);
    chk("busy restart res", 64'(got), 64'(ex));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
